// File: rtl/led_seq_ctrl_pkg.sv
// Shared definitions for the LED sequencer: mode and FSM encodings, plus the
// bouncing-scan step function used by the pattern engine.
package led_seq_ctrl_pkg;

    // Pattern selected by the requester and driven onto the pads
    typedef enum logic [1:0] {
        MODE_BIN     = 2'd0,
        MODE_SCAN    = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_OFF     = 2'd3
    } mode_e;

    // Mode-change handshake states
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SWITCH = 1'b1
    } fsm_e;

    // Bouncing scan position and direction (up = towards bit 7)
    typedef struct packed {
        logic [2:0] pos;
        logic       up;
    } scan_t;

    localparam scan_t SCAN_START = '{pos: 3'd0, up: 1'b1};

    // One scan step; turns at either end without repeating the end position
    function automatic scan_t scan_next(input scan_t s);
        scan_t n;
        n = s;
        if (s.up) begin
            if (s.pos == 3'd7) begin
                n.pos = 3'd6;
                n.up  = 1'b0;
            end else begin
                n.pos = s.pos + 3'd1;
            end
        end else begin
            if (s.pos == 3'd0) begin
                n.pos = 3'd1;
                n.up  = 1'b1;
            end else begin
                n.pos = s.pos - 3'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Free-running prescaler; emits a one-clock tick when the count is all-ones,
// so the pattern engine steps once every 2**PRESC_W clocks.
module led_prescaler #(
    parameter int PRESC_W = 18
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;

    assign presc_d = presc_q + PRESC_W'(1);

    // Terminal-count decode of the registered count
    assign tick = &presc_q;

    // Wrapping up-counter
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: binary count, bouncing scan, PWM breathe or off,
// stepped on a prescaled tick. Mode changes arrive over a valid/ready
// handshake and are applied only on a tick boundary.
module led_seq_ctrl
    import led_seq_ctrl_pkg::*;
#(
    parameter int         PRESC_W    = 18,
    parameter int         PWM_W      = 4,
    parameter logic [1:0] RESET_MODE = 2'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_req_valid,
    input  logic [1:0] mode_req,
    output logic       mode_req_ready,
    output logic [1:0] cur_mode,
    output logic       tick,
    output logic [7:0] leds
);

    localparam logic [PWM_W-1:0] LEVEL_MAX = '1;
    localparam logic [PWM_W-1:0] LEVEL_ONE = PWM_W'(1);

    logic             tick_w;

    fsm_e             fsm_q;
    mode_e            pend_q;
    mode_e            cur_mode_q;
    logic             ready_q;

    logic [7:0]       cnt_q,      cnt_d;
    scan_t            scan_q,     scan_d;
    logic [PWM_W-1:0] level_q,    level_d;
    logic             level_up_q, level_up_d;
    logic [PWM_W-1:0] pwm_q,      pwm_d;
    logic [7:0]       leds_q,     leds_d;

    logic             advance;
    logic             restart;

    led_prescaler #(
        .PRESC_W(PRESC_W)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .tick(tick_w)
    );

    // A tick in RUN steps the active pattern; a tick in SWITCH applies the
    // pending mode and restarts the patterns instead of stepping them.
    assign advance = (fsm_q == ST_RUN)    && tick_w;
    assign restart = (fsm_q == ST_SWITCH) && tick_w;
    assign pwm_d   = pwm_q + LEVEL_ONE;

    // Next pattern state for the active mode
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        cnt_d      = cnt_q;
        scan_d     = scan_q;
        level_d    = level_q;
        level_up_d = level_up_q;
        if (restart) begin
            cnt_d      = '0;
            scan_d     = SCAN_START;
            level_d    = '0;
            level_up_d = 1'b1;
        end else if (advance) begin
            case (cur_mode_q)
                MODE_BIN:  cnt_d  = cnt_q + 8'd1;
                MODE_SCAN: scan_d = scan_next(scan_q);
                MODE_BREATHE: begin
                    if (level_up_q) begin
                        if (level_q == LEVEL_MAX) begin
                            level_d    = level_q - LEVEL_ONE;
                            level_up_d = 1'b0;
                        end else begin
                            level_d = level_q + LEVEL_ONE;
                        end
                    end else begin
                        if (level_q == '0) begin
                            level_d    = LEVEL_ONE;
                            level_up_d = 1'b1;
                        end else begin
                            level_d = level_q - LEVEL_ONE;
                        end
                    end
                end
                default: ; // OFF: pattern state holds
            endcase
        end
    end

    // Pad value for the current mode, pattern state and PWM phase
    always_comb begin
        leds_d = 8'h00;
        case (cur_mode_q)
            MODE_BIN:     leds_d = cnt_q;
            MODE_SCAN:    leds_d = 8'd1 << scan_q.pos;
            MODE_BREATHE: leds_d = (pwm_q < level_q) ? 8'hFF : 8'h00;
            default:      leds_d = 8'h00;
        endcase
    end

    // Mode-change handshake FSM with registered ready and current mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q      <= ST_RUN;
            pend_q     <= MODE_BIN;
            cur_mode_q <= mode_e'(RESET_MODE);
            ready_q    <= 1'b1;
        end else begin
            case (fsm_q)
                ST_RUN: begin
                    if (mode_req_valid && ready_q) begin
                        pend_q  <= mode_e'(mode_req);
                        fsm_q   <= ST_SWITCH;
                        ready_q <= 1'b0;
                    end
                end
                ST_SWITCH: begin
                    if (tick_w) begin
                        cur_mode_q <= pend_q;
                        fsm_q      <= ST_RUN;
                        ready_q    <= 1'b1;
                    end
                end
                default: begin
                    fsm_q   <= ST_RUN;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Pattern state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            scan_q     <= SCAN_START;
            level_q    <= '0;
            level_up_q <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            scan_q     <= scan_d;
            level_q    <= level_d;
            level_up_q <= level_up_d;
        end
    end

    // Free-running PWM phase and registered pad drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_q  <= '0;
            leds_q <= 8'h00;
        end else begin
            pwm_q  <= pwm_d;
            leds_q <= leds_d;
        end
    end

    assign mode_req_ready = ready_q;
    assign cur_mode       = cur_mode_q;
    assign tick           = tick_w;
    assign leds           = leds_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl (tick every 4 clks, 16-clk PWM).
// Reference model: the pattern is a pure function of (mode, steps since
// restart, PWM phase); the prescaler and PWM phases follow from the number of
// clock edges since reset.
module tb_led_seq_ctrl;

    localparam int TICK_PERIOD = 4;
    localparam int PWM_PERIOD  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_req_valid;
    logic [1:0] mode_req;
    logic       mode_req_ready;
    logic [1:0] cur_mode;
    logic       tick;
    logic [7:0] leds;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_cycle;   // clock edges since reset release
    int m_mode;
    int m_k;       // pattern steps since last restart
    bit m_pend_v;
    int m_pend;

    led_seq_ctrl #(
        .PRESC_W   (2),
        .PWM_W     (4),
        .RESET_MODE(2'd0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mode_req_valid(mode_req_valid),
        .mode_req      (mode_req),
        .mode_req_ready(mode_req_ready),
        .cur_mode      (cur_mode),
        .tick          (tick),
        .leds          (leds)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pattern_leds(input int mode, input int k, input int pwm);
        int t;
        int lvl;
        case (mode)
            0: return 8'(k % 256);
            1: begin
                t = k % 14;
                return 8'(1 << ((t <= 7) ? t : 14 - t));
            end
            2: begin
                t   = k % 30;
                lvl = (t <= 15) ? t : 30 - t;
                return (pwm < lvl) ? 8'hFF : 8'h00;
            end
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_cycle  = 0;
        m_mode   = 0;
        m_k      = 0;
        m_pend_v = 1'b0;
        m_pend   = 0;
    endtask

    // Drive one cycle of inputs, predict, advance one clock, compare
    task automatic cyc(input logic v, input logic [1:0] r);
        bit         tk;
        logic [7:0] exp_leds;
        mode_req_valid = v;
        mode_req       = r;
        tk       = (m_cycle % TICK_PERIOD) == TICK_PERIOD - 1;
        exp_leds = pattern_leds(m_mode, m_k, m_cycle % PWM_PERIOD);
        if (m_pend_v) begin
            if (tk) begin
                m_mode   = m_pend;
                m_k      = 0;
                m_pend_v = 1'b0;
            end
        end else begin
            if (tk && m_mode != 3) m_k++;
            if (v) begin
                m_pend   = int'(r);
                m_pend_v = 1'b1;
            end
        end
        m_cycle++;
        @(posedge clk);
        #1;
        check("leds", 32'(leds), 32'(exp_leds));
        check("cur_mode", 32'(cur_mode), 32'(m_mode));
        check("ready", 32'(mode_req_ready), 32'(!m_pend_v));
        check("tick", 32'(tick), 32'((m_cycle % TICK_PERIOD) == TICK_PERIOD - 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int guard;
        rst            = 1'b1;
        mode_req_valid = 1'b0;
        mode_req       = 2'd0;
        #12;
        check("rst_leds", 32'(leds), 32'h00);
        check("rst_ready", 32'(mode_req_ready), 32'd1);
        check("rst_mode", 32'(cur_mode), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // BIN from reset through a full 256-step wrap
        idle(260 * TICK_PERIOD);

        // SCAN: full bounce and beyond
        cyc(1'b1, 2'd1);
        idle(40 * TICK_PERIOD);

        // BREATHE: up to max, back down to 0, and up again
        cyc(1'b1, 2'd2);
        idle(35 * TICK_PERIOD);

        // Request accepted on the tick cycle; valid held with another mode
        guard = 0;
        while (!((m_cycle % TICK_PERIOD) == TICK_PERIOD - 1 && !m_pend_v) && guard < 16) begin
            cyc(1'b0, 2'd0);
            guard++;
        end
        check("wait_tick_phase", 32'(guard < 16), 32'd1);
        cyc(1'b1, 2'd3);
        for (int i = 0; i < 3; i++) cyc(1'b1, 2'd1);
        idle(8);

        // Same-mode restart of BIN at count 0x37
        cyc(1'b1, 2'd0);
        guard = 0;
        while (!(m_mode == 0 && !m_pend_v && m_k == 8'h37) && guard < 400) begin
            cyc(1'b0, 2'd0);
            guard++;
        end
        check("wait_cnt37", 32'(guard < 400), 32'd1);
        cyc(1'b1, 2'd0);
        idle(6 * TICK_PERIOD);

        // Async reset while a SCAN switch is pending
        cyc(1'b1, 2'd1);
        check("pend_before_rst", 32'(mode_req_ready), 32'd0);
        rst = 1'b1;
        #2;
        check("arst_leds", 32'(leds), 32'h00);
        check("arst_ready", 32'(mode_req_ready), 32'd1);
        check("arst_mode", 32'(cur_mode), 32'd0);
        check("arst_tick", 32'(tick), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(10 * TICK_PERIOD);

        // Random requests
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
